// File: rtl/abft_scrub_ctrl_if.sv
// Host-side bundle for the ABFT scrub controller: write, fault-inject, start and read requests
// toward the controller, and the read data and scrub status back to the host.
interface abft_scrub_ctrl_if #(
   parameter int DW    = 8,
   parameter int CNT_W = 8
);
   logic             wr_en;
   logic [1:0]       wr_row;
   logic [1:0]       wr_col;
   logic [DW-1:0]    wr_data;
   logic             inj_en;
   logic [1:0]       inj_row;
   logic [1:0]       inj_col;
   logic [DW-1:0]    inj_mask;
   logic             start;
   logic [1:0]       rd_row;
   logic [1:0]       rd_col;
   logic [DW-1:0]    rd_data;
   logic             busy;
   logic             done;
   logic             err_det;
   logic             err_corr;
   logic             err_uncorr;
   logic [1:0]       err_row;
   logic [1:0]       err_col;
   logic [CNT_W-1:0] corr_cnt;

   modport master (
      output wr_en, wr_row, wr_col, wr_data,
      output inj_en, inj_row, inj_col, inj_mask,
      output start, rd_row, rd_col,
      input  rd_data, busy, done, err_det, err_corr, err_uncorr,
      input  err_row, err_col, corr_cnt
   );

   modport slave (
      input  wr_en, wr_row, wr_col, wr_data,
      input  inj_en, inj_row, inj_col, inj_mask,
      input  start, rd_row, rd_col,
      output rd_data, busy, done, err_det, err_corr, err_uncorr,
      output err_row, err_col, corr_cnt
   );
endinterface

// File: rtl/abft_scrub_ctrl.sv
// ABFT scrub controller for a 4x4 matrix: keeps golden column parities and per-row check bytes,
// rescans the matrix on request, locates a single faulty element and corrects it in place.
module abft_scrub_ctrl #(
   parameter int DW    = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   abft_scrub_ctrl_if.slave bus
);
   typedef logic [3:0][DW-1:0] row_t;
   typedef logic [2:0][DW-1:0] chk_t;
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_EVAL, S_FIX, S_DONE} state_e;

   state_e           state_q, state_d;
   row_t [3:0]       mat_q, mat_d;
   row_t             gpar_q, gpar_d;
   chk_t [3:0]       chk_q, chk_d;
   row_t             facc_q, facc_d;
   logic [3:0]       rflag_q, rflag_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       loc_row_q, loc_row_d;
   logic [1:0]       loc_col_q, loc_col_d;
   logic [DW-1:0]    rd_q, rd_d;
   logic             det_q, det_d;
   logic             corr_q, corr_d;
   logic             unc_q, unc_d;
   logic [1:0]       erow_q, erow_d;
   logic [1:0]       ecol_q, ecol_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   row_t             syn;
   logic [3:0]       cflag;
   row_t             wr_row_new;

   // Three overlapping XOR checks per row; a single bad element disturbs a unique subset.
   function automatic chk_t row_chk(input row_t r);
      chk_t z;
      z[0] = r[0] ^ r[1] ^ r[2];
      z[1] = r[0] ^ r[1] ^ r[3];
      z[2] = r[0] ^ r[2] ^ r[3];
      return z;
   endfunction

   function automatic logic [1:0] lowest(input logic [3:0] f);
      logic [1:0] i;
      i = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (f[k]) i = 2'(k);
      end
      return i;
   endfunction

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         syn[c]   = gpar_q[c] ^ facc_q[c];
         cflag[c] = |syn[c];
      end
   end

   always_comb begin
      state_d    = state_q;
      mat_d      = mat_q;
      gpar_d     = gpar_q;
      chk_d      = chk_q;
      facc_d     = facc_q;
      rflag_d    = rflag_q;
      idx_d      = idx_q;
      loc_row_d  = loc_row_q;
      loc_col_d  = loc_col_q;
      det_d      = det_q;
      corr_d     = corr_q;
      unc_d      = unc_q;
      erow_d     = erow_q;
      ecol_d     = ecol_q;
      cnt_d      = cnt_q;
      rd_d       = mat_q[bus.rd_row][bus.rd_col];
      wr_row_new = mat_q[bus.wr_row];
      wr_row_new[bus.wr_col] = bus.wr_data;

      unique case (state_q)
         S_IDLE: begin
            if (bus.wr_en) begin
               mat_d[bus.wr_row][bus.wr_col] = bus.wr_data;
               gpar_d[bus.wr_col] = gpar_q[bus.wr_col] ^ mat_q[bus.wr_row][bus.wr_col] ^ bus.wr_data;
               chk_d[bus.wr_row]  = row_chk(wr_row_new);
            end else if (bus.inj_en) begin
               mat_d[bus.inj_row][bus.inj_col] = mat_q[bus.inj_row][bus.inj_col] ^ bus.inj_mask;
            end
            // A write in the start cycle lands before the first scanned row is read.
            if (bus.start) begin
               state_d = S_SCAN;
               idx_d   = 2'd0;
               facc_d  = '0;
               rflag_d = '0;
               det_d   = 1'b0;
               corr_d  = 1'b0;
               unc_d   = 1'b0;
               erow_d  = 2'd0;
               ecol_d  = 2'd0;
            end
         end

         S_SCAN: begin
            for (int c = 0; c < 4; c++) begin
               facc_d[c] = facc_q[c] ^ mat_q[idx_q][c];
            end
            rflag_d[idx_q] = (row_chk(mat_q[idx_q]) != chk_q[idx_q]);
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = S_EVAL;
         end

         S_EVAL: begin
            if ((rflag_q == 4'd0) && (cflag == 4'd0)) begin
               state_d = S_DONE;
            end else if ($onehot(rflag_q) && $onehot(cflag)) begin
               loc_row_d = lowest(rflag_q);
               loc_col_d = lowest(cflag);
               state_d   = S_FIX;
            end else begin
               det_d   = 1'b1;
               unc_d   = 1'b1;
               erow_d  = lowest(rflag_q);
               ecol_d  = lowest(cflag);
               state_d = S_DONE;
            end
         end

         S_FIX: begin
            // The column syndrome is exactly the flipped-bit pattern of the located element.
            mat_d[loc_row_q][loc_col_q] = mat_q[loc_row_q][loc_col_q] ^ syn[loc_col_q];
            det_d  = 1'b1;
            corr_d = 1'b1;
            erow_d = loc_row_q;
            ecol_d = loc_col_q;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mat_q     <= '0;
         gpar_q    <= '0;
         chk_q     <= '0;
         facc_q    <= '0;
         rflag_q   <= '0;
         idx_q     <= '0;
         loc_row_q <= '0;
         loc_col_q <= '0;
         rd_q      <= '0;
         det_q     <= 1'b0;
         corr_q    <= 1'b0;
         unc_q     <= 1'b0;
         erow_q    <= '0;
         ecol_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mat_q     <= mat_d;
         gpar_q    <= gpar_d;
         chk_q     <= chk_d;
         facc_q    <= facc_d;
         rflag_q   <= rflag_d;
         idx_q     <= idx_d;
         loc_row_q <= loc_row_d;
         loc_col_q <= loc_col_d;
         rd_q      <= rd_d;
         det_q     <= det_d;
         corr_q    <= corr_d;
         unc_q     <= unc_d;
         erow_q    <= erow_d;
         ecol_q    <= ecol_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.rd_data    = rd_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.err_det    = det_q;
   assign bus.err_corr   = corr_q;
   assign bus.err_uncorr = unc_q;
   assign bus.err_row    = erow_q;
   assign bus.err_col    = ecol_q;
   assign bus.corr_cnt   = cnt_q;

endmodule

// File: tb/tb_abft_scrub_ctrl.sv
// Directed bench for abft_scrub_ctrl: a matrix-level model predicts every output each cycle,
// and hand-computed literals pin the key scenarios.
module tb_abft_scrub_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   abft_scrub_ctrl_if #(.DW(8), .CNT_W(8)) b ();
   abft_scrub_ctrl #(.DW(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   logic [7:0] rows [4][4] = '{'{8'd150, 8'd200, 8'd250, 8'd180},
                               '{8'd60,  8'd80,  8'd100, 8'd72},
                               '{8'd120, 8'd160, 8'd200, 8'd144},
                               '{8'd90,  8'd120, 8'd150, 8'd108}};

   // Model state: matrix, golden column parity, stored row checks, pass timeline, status.
   logic [7:0] mm [4][4];
   logic [7:0] mg [4];
   logic [7:0] mz [4][3];
   bit         mbusy;
   int         mk, md;
   bit         p_clean, p_corr;
   int         p_row, p_col;
   logic [7:0] p_fix;
   logic [7:0] e_rd;
   bit         e_det, e_corr, e_unc;
   int         e_row, e_col, e_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_eval();
      logic [3:0] rf, cf;
      logic [7:0] s [4];
      logic [7:0] f;
      rf = '0;
      cf = '0;
      for (int r = 0; r < 4; r++) begin
         if (((mm[r][0] ^ mm[r][1] ^ mm[r][2]) != mz[r][0]) ||
             ((mm[r][0] ^ mm[r][1] ^ mm[r][3]) != mz[r][1]) ||
             ((mm[r][0] ^ mm[r][2] ^ mm[r][3]) != mz[r][2])) rf[r] = 1'b1;
      end
      for (int c = 0; c < 4; c++) begin
         f = mg[c];
         for (int r = 0; r < 4; r++) f = f ^ mm[r][c];
         s[c] = f;
         if (f != 8'd0) cf[c] = 1'b1;
      end
      p_row = 0;
      p_col = 0;
      for (int i = 3; i >= 0; i--) begin
         if (rf[i]) p_row = i;
         if (cf[i]) p_col = i;
      end
      p_clean = (rf == 4'd0) && (cf == 4'd0);
      p_corr  = ($countones(rf) == 1) && ($countones(cf) == 1);
      p_fix   = s[p_col];
      md      = p_corr ? 6 : 5;
   endtask

   task automatic model_step();
      if (rst) begin
         for (int r = 0; r < 4; r++) begin
            mg[r] = 8'd0;
            for (int c = 0; c < 4; c++) mm[r][c] = 8'd0;
            for (int j = 0; j < 3; j++) mz[r][j] = 8'd0;
         end
         mbusy = 1'b0; mk = 0; md = 5;
         e_rd = 8'd0; e_det = 1'b0; e_corr = 1'b0; e_unc = 1'b0;
         e_row = 0; e_col = 0; e_cnt = 0;
         return;
      end
      e_rd = mm[b.rd_row][b.rd_col];
      if (!mbusy) begin
         if (b.wr_en) begin
            mg[b.wr_col] = mg[b.wr_col] ^ mm[b.wr_row][b.wr_col] ^ b.wr_data;
            mm[b.wr_row][b.wr_col] = b.wr_data;
            mz[b.wr_row][0] = mm[b.wr_row][0] ^ mm[b.wr_row][1] ^ mm[b.wr_row][2];
            mz[b.wr_row][1] = mm[b.wr_row][0] ^ mm[b.wr_row][1] ^ mm[b.wr_row][3];
            mz[b.wr_row][2] = mm[b.wr_row][0] ^ mm[b.wr_row][2] ^ mm[b.wr_row][3];
         end else if (b.inj_en) begin
            mm[b.inj_row][b.inj_col] = mm[b.inj_row][b.inj_col] ^ b.inj_mask;
         end
         if (b.start) begin
            mbusy = 1'b1; mk = 0;
            e_det = 1'b0; e_corr = 1'b0; e_unc = 1'b0; e_row = 0; e_col = 0;
            model_eval();
         end
      end else begin
         mk++;
         if (mk == md) begin
            if (p_corr) begin
               mm[p_row][p_col] = mm[p_row][p_col] ^ p_fix;
               e_det = 1'b1; e_corr = 1'b1; e_row = p_row; e_col = p_col;
               if (e_cnt < 255) e_cnt++;
            end else if (!p_clean) begin
               e_det = 1'b1; e_unc = 1'b1; e_row = p_row; e_col = p_col;
            end
         end else if (mk == md + 1) begin
            mbusy = 1'b0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("busy", b.busy, 32'(mbusy));
         check("done", b.done, 32'(mbusy && (mk == md)));
         check("err_det", b.err_det, 32'(e_det));
         check("err_corr", b.err_corr, 32'(e_corr));
         check("err_uncorr", b.err_uncorr, 32'(e_unc));
         check("err_row", b.err_row, e_row);
         check("err_col", b.err_col, e_col);
         check("corr_cnt", b.corr_cnt, e_cnt);
         check("rd_data", b.rd_data, e_rd);
      end
   end

   task automatic wr(input int r, input int c, input logic [7:0] d);
      @(negedge clk);
      b.wr_en = 1'b1; b.wr_row = 2'(r); b.wr_col = 2'(c); b.wr_data = d;
      @(negedge clk);
      b.wr_en = 1'b0;
   endtask

   task automatic inject(input int r, input int c, input logic [7:0] m);
      @(negedge clk);
      b.inj_en = 1'b1; b.inj_row = 2'(r); b.inj_col = 2'(c); b.inj_mask = m;
      @(negedge clk);
      b.inj_en = 1'b0;
   endtask

   task automatic load();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) wr(r, c, rows[r][c]);
   endtask

   task automatic rd_chk(input string name, input int r, input int c, input int exp);
      @(negedge clk);
      b.rd_row = 2'(r); b.rd_col = 2'(c);
      @(negedge clk);
      check(name, b.rd_data, exp);
   endtask

   // n counts cycles after the start-sampling edge; returns at the cycle done is seen (or 20).
   task automatic run_pass(output int n);
      @(negedge clk);
      b.start = 1'b1;
      @(negedge clk);
      b.start = 1'b0;
      n = 1;
      while (b.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      b.wr_en = 1'b0; b.wr_row = 2'd0; b.wr_col = 2'd0; b.wr_data = 8'd0;
      b.inj_en = 1'b0; b.inj_row = 2'd0; b.inj_col = 2'd0; b.inj_mask = 8'd0;
      b.start = 1'b0; b.rd_row = 2'd0; b.rd_col = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      check("rst_busy", b.busy, 0);
      check("rst_cnt", b.corr_cnt, 0);
      rd_chk("rst_rd", 1, 1, 0);

      // Clean pass
      load();
      run_pass(n);
      check("t1_lat", n, 6);
      check("t1_det", b.err_det, 0);
      check("t1_cnt", b.corr_cnt, 0);

      // Single error corrected: 80 ^ 0x16 = 70
      inject(1, 1, 8'h16);
      rd_chk("t2_inj", 1, 1, 70);
      run_pass(n);
      check("t2_lat", n, 7);
      check("t2_corr", b.err_corr, 1);
      check("t2_row", b.err_row, 1);
      check("t2_col", b.err_col, 1);
      check("t2_cnt", b.corr_cnt, 1);
      rd_chk("t2_rd", 1, 1, 80);

      // Two errors: uncorrectable, lowest flagged row/col reported
      inject(0, 2, 8'h01);
      inject(3, 0, 8'h80);
      run_pass(n);
      check("t3_lat", n, 6);
      check("t3_unc", b.err_uncorr, 1);
      check("t3_corr", b.err_corr, 0);
      check("t3_row", b.err_row, 0);
      check("t3_col", b.err_col, 0);
      check("t3_cnt", b.corr_cnt, 1);
      rd_chk("t3_rd02", 0, 2, 251);
      rd_chk("t3_rd30", 3, 0, 218);

      // Fresh state, then start/write during SCAN are ignored
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      load();
      @(negedge clk); b.start = 1'b1;
      @(negedge clk); b.start = 1'b0; n = 1;
      @(negedge clk); n = 2;
      b.start = 1'b1; b.wr_en = 1'b1; b.wr_row = 2'd2; b.wr_col = 2'd2; b.wr_data = 8'd0;
      @(negedge clk); n = 3;
      b.start = 1'b0; b.wr_en = 1'b0;
      while (b.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_lat", n, 6);
      check("t4_det", b.err_det, 0);
      rd_chk("t4_rd", 2, 2, 200);
      repeat (3) @(negedge clk);
      check("t4_idle", b.busy, 0);

      // Reset in the middle of a pass after an inject
      inject(0, 0, 8'h01);
      @(negedge clk); b.start = 1'b1;
      @(negedge clk); b.start = 1'b0;
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk);
      check("t5_busy", b.busy, 0);
      check("t5_done", b.done, 0);
      rst = 1'b0;
      rd_chk("t5_rd00", 0, 0, 0);
      rd_chk("t5_rd11", 1, 1, 0);
      rd_chk("t5_rd33", 3, 3, 0);
      check("t5_cnt", b.corr_cnt, 0);
      run_pass(n);
      check("t5_lat", n, 6);
      check("t5_det", b.err_det, 0);

      // Saturating corrected-error counter
      load();
      for (int i = 0; i < 256; i++) begin
         inject(2, 3, 8'h01);
         run_pass(n);
         check("t6_lat", n, 7);
         if (i == 254) check("t6_cnt255", b.corr_cnt, 255);
      end
      check("t6_sat", b.corr_cnt, 255);
      check("t6_corr", b.err_corr, 1);
      rd_chk("t6_rd", 2, 3, 144);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
